// File: rtl/hex_disp_arbiter.sv
// Two-requester arbiter with minimum hold time feeding an 8-digit 7-segment display.
// Grants are combinational; HEX outputs are registered one cycle behind the transfer or blank_lz change.
module hex_disp_arbiter #(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        blank_lz,
  output logic [1:0]  owner,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       value_q, value_d;
  logic              last_b_q, last_b_d;
  logic [7:0][6:0]   hex_q, hex_d;
  logic              a_rdy, b_rdy;
  logic              xfer_a, xfer_b;
  logic              seen_nz;
  logic [3:0]        dig;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Grant: in IDLE contention goes to the side not granted last; an expired owner yields to a waiting peer.
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid && b_valid) begin
          a_rdy = last_b_q;
          b_rdy = !last_b_q;
        end else begin
          a_rdy = a_valid;
          b_rdy = b_valid;
        end
      end
      OWN_A: begin
        if (cnt_q != '0)  a_rdy = 1'b1;
        else if (b_valid) b_rdy = 1'b1;
        else              a_rdy = 1'b1;
      end
      OWN_B: begin
        if (cnt_q != '0)  b_rdy = 1'b1;
        else if (a_valid) a_rdy = 1'b1;
        else              b_rdy = 1'b1;
      end
      default: begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
      end
    endcase
    if (rst) begin
      a_rdy = 1'b0;
      b_rdy = 1'b0;
    end
  end

  assign xfer_a = a_valid && a_rdy;
  assign xfer_b = b_valid && b_rdy;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    last_b_d = last_b_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    if (xfer_a) begin
      state_d  = OWN_A;
      value_d  = a_data;
      last_b_d = 1'b0;
      cnt_d    = RELOAD;
    end else if (xfer_b) begin
      state_d  = OWN_B;
      value_d  = b_data;
      last_b_d = 1'b1;
      cnt_d    = RELOAD;
    end
  end

  // Decode from the next value so the display lands on the edge that performs the transfer.
  always_comb begin
    hex_d   = '0;
    seen_nz = 1'b0;
    dig     = 4'h0;
    for (int n = 7; n >= 0; n--) begin
      dig = value_d[4*n +: 4];
      if (dig != 4'h0) seen_nz = 1'b1;
      if (blank_lz && !seen_nz && (n != 0)) hex_d[n] = SEG_BLANK;
      else                                  hex_d[n] = seg7(dig);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      value_q  <= '0;
      last_b_q <= 1'b1;
      hex_q    <= {8{SEG_ZERO}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      last_b_q <= last_b_d;
      hex_q    <= hex_d;
    end
  end

  assign a_ready = a_rdy;
  assign b_ready = b_rdy;
  assign owner   = state_q;
  assign HEX0    = hex_q[0];
  assign HEX1    = hex_q[1];
  assign HEX2    = hex_q[2];
  assign HEX3    = hex_q[3];
  assign HEX4    = hex_q[4];
  assign HEX5    = hex_q[5];
  assign HEX6    = hex_q[6];
  assign HEX7    = hex_q[7];

endmodule

// File: tb/tb_hex_disp_arbiter.sv
// Directed bench for hex_disp_arbiter with HOLD_CYCLES=4.
module tb_hex_disp_arbiter;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, blank_lz = 1'b0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic [1:0]  owner;
  logic [6:0]  hex [8];
  int          errors = 0;
  int          checks = 0;

  hex_disp_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .blank_lz(blank_lz), .owner(owner),
    .HEX0(hex[0]), .HEX1(hex[1]), .HEX2(hex[2]), .HEX3(hex[3]),
    .HEX4(hex[4]), .HEX5(hex[5]), .HEX6(hex[6]), .HEX7(hex[7])
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (a_ready && b_ready) begin
      errors++;
      $display("FAIL mutex: a_ready=%b b_ready=%b both set at %0t", a_ready, b_ready, $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0; blank_lz = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] r;
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    tick(); tick();
    r = {a_ready, b_ready};
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", r); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rst_owner: got %b want 00", owner); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (hex[i] !== S0) begin errors++; $display("FAIL rst_hex%0d: got %b want %b", i, hex[i], S0); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
    tick();
    r = {a_ready, b_ready};
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b want 00", r); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL idle_owner: got %b want 00", owner); end
  endtask

  task automatic test_single_a();
    logic [6:0] exp [8];
    exp = '{S1, SF, S0, S0, S0, S0, S0, S0};
    a_valid = 1'b1; a_data = 32'h0000_00F1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {a_ready, b_ready}); end
    tick();
    a_valid = 1'b0;
    #1;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL single_owner: got %b want 01", owner); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (hex[i] !== exp[i]) begin errors++; $display("FAIL single_hex%0d: got %b want %b", i, hex[i], exp[i]); end
    end
  endtask

  task automatic test_blank();
    logic [6:0] e1 [8];
    logic [6:0] e2 [8];
    logic [6:0] e3 [8];
    e1 = '{S1, SF, BL, BL, BL, BL, BL, BL};
    e2 = '{S0, S0, S2, S0, S1, BL, BL, BL};
    e3 = '{S0, BL, BL, BL, BL, BL, BL, BL};
    blank_lz = 1'b1;
    #1;
    checks++; if (hex[2] !== S0) begin errors++; $display("FAIL blank_latency: got %b want %b", hex[2], S0); end
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++; if (hex[i] !== e1[i]) begin errors++; $display("FAIL blank_f1_hex%0d: got %b want %b", i, hex[i], e1[i]); end
    end
    a_valid = 1'b1; a_data = 32'h0001_0200;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (hex[i] !== e2[i]) begin errors++; $display("FAIL blank_mid_hex%0d: got %b want %b", i, hex[i], e2[i]); end
    end
    a_valid = 1'b1; a_data = 32'h0;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (hex[i] !== e3[i]) begin errors++; $display("FAIL blank_zero_hex%0d: got %b want %b", i, hex[i], e3[i]); end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_contend();
    logic [6:0] exp [8];
    exp = '{7'b0100001, 7'b0110000, 7'b0000110, 7'b1000000,
            7'b1000110, 7'b0010010, 7'b0001000, 7'b0000000};
    a_data = 32'h1111_1111; b_data = 32'h8A5C_0E3D;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL contend_first: got %b want 10", {a_ready, b_ready}); end
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL contend_hold%0d: got %b want 10", c, {a_ready, b_ready}); end
      checks++; if (owner !== 2'b01) begin errors++; $display("FAIL contend_owner%0d: got %b want 01", c, owner); end
      tick();
    end
    a_valid = 1'b1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL contend_expiry: got %b want 01", {a_ready, b_ready}); end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL contend_owner_b: got %b want 10", owner); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (hex[i] !== exp[i]) begin errors++; $display("FAIL contend_hex%0d: got %b want %b", i, hex[i], exp[i]); end
    end
    for (int c = 0; c < 5; c++) tick();
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL idle_keep_owner: got %b want 10", owner); end
    checks++; if (hex[0] !== exp[0]) begin errors++; $display("FAIL idle_keep_hex0: got %b want %b", hex[0], exp[0]); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp [8];
    exp = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0011001,
            7'b0000010, 7'b0000011, 7'b1111000, 7'b0010000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1;
      a_data = (i == 5) ? 32'h97B6_4210 : 32'(i);
      #1;
      checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL b2b_ready%0d: got %b want 10", i, {a_ready, b_ready}); end
      if (i > 0) begin
        checks++; if (owner !== 2'b01) begin errors++; $display("FAIL b2b_owner%0d: got %b want 01", i, owner); end
      end
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b1;
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL b2b_reload: b_ready got %b want 0", b_ready); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (hex[i] !== exp[i]) begin errors++; $display("FAIL b2b_hex%0d: got %b want %b", i, hex[i], exp[i]); end
    end
    b_valid = 1'b0;
    tick(); tick(); tick();
    b_valid = 1'b1; b_data = 32'h0000_0005;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL b2b_handover: got %b want 01", {a_ready, b_ready}); end
    tick();
    b_valid = 1'b0;
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL b2b_owner_b: got %b want 10", owner); end
  endtask

  task automatic test_async_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL arst_pre: got %b want 01", {a_ready, b_ready}); end
    #2 rst = 1'b1;
    #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL arst_owner: got %b want 00", owner); end
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL arst_ready: got %b want 00", {a_ready, b_ready}); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (hex[i] !== S0) begin errors++; $display("FAIL arst_hex%0d: got %b want %b", i, hex[i], S0); end
    end
    #1 rst = 1'b0;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL arst_regrant: got %b want 10", {a_ready, b_ready}); end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL arst_owner_a: got %b want 01", owner); end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_blank();
    do_reset();
    test_contend();
    test_back_to_back();
    test_async_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
